pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage MIPS core. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 23 ++
 rtl/hazard_fwd_unit.sv | 34 +++
 rtl/pipe_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the 5-stage pipeline hazard controller.
//   ctrl_state_e : sequencer state codes (RUN / STALL)
//   FWD_*        : ALU operand source select codes driven on fwd_a / fwd_b
//   regMatch     : "producer writes the register this consumer reads" test,
//                  with register 0 never matching (it is hard-wired to zero)
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1
  } ctrl_state_e;

  localparam logic [1:0] FWD_REG = 2'b00;  // operand from the register file
  localparam logic [1:0] FWD_MEM = 2'b01;  // operand from EX/MEM aluOut
  localparam logic [1:0] FWD_WB  = 2'b10;  // operand from MEM/WB writeback value

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic regMatch(input logic [4:0] dest, input logic [4:0] src);
    return (dest != REG_ZERO) && (dest == src);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forward-select logic for one ALU operand of the instruction in EX.
// Ports:
//   src      in  5  source register field of the instruction held in ID/EX
//   m_regW   in  1  EX/MEM instruction writes a GPR
//   m_memR   in  1  EX/MEM instruction is a load (its value is not ready yet)
//   m_dest   in  5  EX/MEM destination register
//   wb_regW  in  1  MEM/WB instruction writes a GPR
//   wb_dest  in  5  MEM/WB destination register
//   fwdSel   out 2  FWD_REG / FWD_MEM / FWD_WB
module hazard_fwd_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic       m_regW,
  input  logic       m_memR,
  input  logic [4:0] m_dest,
  input  logic       wb_regW,
  input  logic [4:0] wb_dest,
  output logic [1:0] fwdSel
);

  // The younger producer (EX/MEM) holds the newer value, so it wins a double
  // match. A load in EX/MEM has only an address in aluOut, so it cannot
  // forward from there; its data arrives through MEM/WB one cycle later.
  always_comb begin
    fwdSel = FWD_REG;
    if (m_regW && !m_memR && regMatch(m_dest, src)) begin
      fwdSel = FWD_MEM;
    end else if (wb_regW && regMatch(wb_dest, src)) begin
      fwdSel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core.
// Drives PC / pipeline-register write enables and clears, and the EX operand
// forward selects, handling load-use stalls, taken-branch flushes (branch
// resolved in MEM) and an external global hold. Counts stall cycles and
// flushes in saturating counters.
// Parameters:
//   LU_STALL  bubbles per load-use hazard (1..3)
//   CNT_W     width of each performance counter
// Ports:
//   clock, reset (async, active-low), ext_hold
//   id_rs, id_rt                     source fields of the instruction in ID
//   ex_memR, ex_regW, ex_dest        ID/EX instruction info
//   m_regW, m_memR, m_dest,
//   m_branch, m_zero                 EX/MEM instruction info
//   wb_regW, wb_dest                 MEM/WB instruction info
//   pc_write, *_write, *_clear       pipeline register control
//   fwd_a, fwd_b                     ALU operand source selects
//   stall_cnt, flush_cnt             saturating performance counters
//   dbg_state                        current sequencer state (ctrl_state_e code)
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int LU_STALL = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ext_hold,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memR,
  input  logic             ex_regW,
  input  logic [4:0]       ex_dest,
  input  logic             m_regW,
  input  logic             m_memR,
  input  logic [4:0]       m_dest,
  input  logic             m_branch,
  input  logic             m_zero,
  input  logic             wb_regW,
  input  logic [4:0]       wb_dest,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_clear,
  output logic             id_ex_write,
  output logic             id_ex_clear,
  output logic             ex_m_write,
  output logic             ex_m_clear,
  output logic             m_wb_write,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       dbg_state
);

  // Remaining bubbles after the first one; loaded when a hazard is detected.
  localparam logic [1:0] STALL_RELOAD = 2'(LU_STALL - 1);

  ctrl_state_e      stateQ, stateD;
  logic [1:0]       cntQ, cntD;
  logic [CNT_W-1:0] stallCntQ, flushCntQ;
  logic             stallInc, flushInc;
  logic             luHaz, brTk;

  // Copy of the rs/rt fields travelling alongside the ID/EX register, so the
  // forward selects look at the instruction actually executing in EX.
  logic [4:0]       exRsQ, exRtQ;
  logic [1:0]       fwdARaw, fwdBRaw;

  assign luHaz = ex_memR && ex_regW && (regMatch(ex_dest, id_rs) || regMatch(ex_dest, id_rt));
  assign brTk  = m_branch && m_zero;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateQ <= ST_RUN;
      cntQ   <= 2'd0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    stateD      = stateQ;
    cntD        = cntQ;
    stallInc    = 1'b0;
    flushInc    = 1'b0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_clear = 1'b0;
    id_ex_write = 1'b1;
    id_ex_clear = 1'b0;
    ex_m_write  = 1'b1;
    ex_m_clear  = 1'b0;
    m_wb_write  = 1'b1;

    if (ext_hold) begin
      // Freeze everything; a branch sitting in EX/MEM is still there next cycle.
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      ex_m_write  = 1'b0;
      m_wb_write  = 1'b0;
    end else if (brTk) begin
      // Squash the three younger instructions; PC loads the branch target.
      if_id_clear = 1'b1;
      id_ex_clear = 1'b1;
      ex_m_clear  = 1'b1;
      stateD      = ST_RUN;
      cntD        = 2'd0;
      flushInc    = 1'b1;
    end else begin
      case (stateQ)
        ST_RUN: begin
          if (luHaz) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_clear = 1'b1;
            stallInc    = 1'b1;
            if (LU_STALL > 1) begin
              stateD = ST_STALL;
              cntD   = STALL_RELOAD;
            end
          end
        end
        ST_STALL: begin
          // Bubble count is fixed once started; new hazards are not sampled.
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_clear = 1'b1;
          stallInc    = 1'b1;
          cntD        = cntQ - 2'd1;
          if (cntQ == 2'd1) begin
            stateD = ST_RUN;
          end
        end
        default: begin
          stateD = ST_RUN;
          cntD   = 2'd0;
        end
      endcase
    end

    // While reset is held the pipeline runs free with no clears.
    if (!reset) begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_clear = 1'b0;
      id_ex_write = 1'b1;
      id_ex_clear = 1'b0;
      ex_m_write  = 1'b1;
      ex_m_clear  = 1'b0;
      m_wb_write  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // ID/EX source-field shadow (follows the ID/EX write/clear controls)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      exRsQ <= REG_ZERO;
      exRtQ <= REG_ZERO;
    end else if (id_ex_write) begin
      if (id_ex_clear) begin
        exRsQ <= REG_ZERO;
        exRtQ <= REG_ZERO;
      end else begin
        exRsQ <= id_rs;
        exRtQ <= id_rt;
      end
    end
  end

  hazard_fwd_unit uFwdA (
    .src     (exRsQ),
    .m_regW  (m_regW),
    .m_memR  (m_memR),
    .m_dest  (m_dest),
    .wb_regW (wb_regW),
    .wb_dest (wb_dest),
    .fwdSel  (fwdARaw)
  );

  hazard_fwd_unit uFwdB (
    .src     (exRtQ),
    .m_regW  (m_regW),
    .m_memR  (m_memR),
    .m_dest  (m_dest),
    .wb_regW (wb_regW),
    .wb_dest (wb_dest),
    .fwdSel  (fwdBRaw)
  );

  assign fwd_a = reset ? fwdARaw : FWD_REG;
  assign fwd_b = reset ? fwdBRaw : FWD_REG;

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stallCntQ <= '0;
      flushCntQ <= '0;
    end else begin
      if (stallInc && !(&stallCntQ)) begin
        stallCntQ <= stallCntQ + CNT_W'(1);
      end
      if (flushInc && !(&flushCntQ)) begin
        flushCntQ <= flushCntQ + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stallCntQ;
  assign flush_cnt = flushCntQ;
  assign dbg_state = stateQ;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (LU_STALL = 1, 2, 3) share one
// set of inputs; a per-instance behavioural model tracks outstanding bubbles,
// event counts and the source fields of the instruction in EX.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int ND      = 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT inputs ----------------
  logic       ext_hold = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_dest = '0, m_dest = '0, wb_dest = '0;
  logic       ex_memR = 1'b0, ex_regW = 1'b0, m_regW = 1'b0, m_memR = 1'b0;
  logic       m_branch = 1'b0, m_zero = 1'b0, wb_regW = 1'b0;

  // ---------------- DUT outputs ----------------
  logic [ND-1:0] pc_write, if_id_write, if_id_clear, id_ex_write, id_ex_clear;
  logic [ND-1:0] ex_m_write, ex_m_clear, m_wb_write;
  logic [1:0]    fwd_a [ND];
  logic [1:0]    fwd_b [ND];
  logic [CW-1:0] stall_cnt [ND];
  logic [CW-1:0] flush_cnt [ND];
  logic [1:0]    dbg_state [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    pipe_hazard_ctrl #(.LU_STALL(g + 1), .CNT_W(CW)) dut (
      .clock       (clock),
      .reset       (reset),
      .ext_hold    (ext_hold),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .ex_memR     (ex_memR),
      .ex_regW     (ex_regW),
      .ex_dest     (ex_dest),
      .m_regW      (m_regW),
      .m_memR      (m_memR),
      .m_dest      (m_dest),
      .m_branch    (m_branch),
      .m_zero      (m_zero),
      .wb_regW     (wb_regW),
      .wb_dest     (wb_dest),
      .pc_write    (pc_write[g]),
      .if_id_write (if_id_write[g]),
      .if_id_clear (if_id_clear[g]),
      .id_ex_write (id_ex_write[g]),
      .id_ex_clear (id_ex_clear[g]),
      .ex_m_write  (ex_m_write[g]),
      .ex_m_clear  (ex_m_clear[g]),
      .m_wb_write  (m_wb_write[g]),
      .fwd_a       (fwd_a[g]),
      .fwd_b       (fwd_b[g]),
      .stall_cnt   (stall_cnt[g]),
      .flush_cnt   (flush_cnt[g]),
      .dbg_state   (dbg_state[g])
    );
  end

  // ---------------- reference model ----------------
  int         m_bub   [ND];   // stall cycles still owed after the current one
  int         m_stall [ND];
  int         m_flush [ND];
  logic [4:0] m_exrs  [ND];
  logic [4:0] m_exrt  [ND];

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [1:0] mdl_fwd(input logic [4:0] src);
    if (m_regW && !m_memR && m_dest != 5'd0 && m_dest == src) return 2'b01;
    if (wb_regW && wb_dest != 5'd0 && wb_dest == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic cmp(input string tag, input int g, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, g, obs, exp);
    end
  endtask

  // Control vector order:
  // {pc_write, if_id_write, if_id_clear, id_ex_write, id_ex_clear, ex_m_write, ex_m_clear, m_wb_write}
  localparam logic [7:0] C_RUN   = 8'b1101_0101;
  localparam logic [7:0] C_HOLD  = 8'b0000_0000;
  localparam logic [7:0] C_FLUSH = 8'b1111_1111;
  localparam logic [7:0] C_STALL = 8'b0001_1101;

  // One clock: check outputs at the falling edge, advance the model, then
  // return just after the next rising edge so new inputs can be driven.
  task automatic tick();
    logic       lu, br, stl;
    logic [7:0] ec, oc;
    @(negedge clock);
    lu = ex_memR && ex_regW && ex_dest != 5'd0 && (ex_dest == id_rs || ex_dest == id_rt);
    br = m_branch && m_zero;
    for (int g = 0; g < ND; g++) begin
      if (!reset) begin
        m_bub[g] = 0; m_stall[g] = 0; m_flush[g] = 0;
        m_exrs[g] = 5'd0; m_exrt[g] = 5'd0;
      end
      stl = (m_bub[g] > 0) || lu;
      if (!reset)        ec = C_RUN;
      else if (ext_hold) ec = C_HOLD;
      else if (br)       ec = C_FLUSH;
      else if (stl)      ec = C_STALL;
      else               ec = C_RUN;
      oc = {pc_write[g], if_id_write[g], if_id_clear[g], id_ex_write[g],
            id_ex_clear[g], ex_m_write[g], ex_m_clear[g], m_wb_write[g]};
      cmp("ctrl", g, oc, ec);
      cmp("fwd_a", g, {6'd0, fwd_a[g]}, reset ? {6'd0, mdl_fwd(m_exrs[g])} : 8'd0);
      cmp("fwd_b", g, {6'd0, fwd_b[g]}, reset ? {6'd0, mdl_fwd(m_exrt[g])} : 8'd0);
      cmp("stall_cnt", g, {4'd0, stall_cnt[g]}, 8'(m_stall[g]));
      cmp("flush_cnt", g, {4'd0, flush_cnt[g]}, 8'(m_flush[g]));
      cmp("state", g, {6'd0, dbg_state[g]}, (m_bub[g] > 0) ? 8'(ST_STALL) : 8'(ST_RUN));
      if (reset && !ext_hold) begin
        if (br) begin
          m_bub[g] = 0;
          if (m_flush[g] < CNT_MAX) m_flush[g]++;
          m_exrs[g] = 5'd0; m_exrt[g] = 5'd0;
        end else if (stl) begin
          m_bub[g] = (m_bub[g] > 0) ? m_bub[g] - 1 : g;  // instance g has LU_STALL = g+1
          if (m_stall[g] < CNT_MAX) m_stall[g]++;
          m_exrs[g] = 5'd0; m_exrt[g] = 5'd0;
        end else begin
          m_exrs[g] = id_rs; m_exrt[g] = id_rt;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ext_hold = 0; id_rs = 0; id_rt = 0; ex_memR = 0; ex_regW = 0; ex_dest = 0;
    m_regW = 0; m_memR = 0; m_dest = 0; m_branch = 0; m_zero = 0;
    wb_regW = 0; wb_dest = 0;
  endtask

  task automatic set_lw_hazard(input logic [4:0] dest);
    ex_memR = 1; ex_regW = 1; ex_dest = dest; id_rs = dest; id_rt = 5'd0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int g = 0; g < ND; g++) begin
      m_bub[g] = 0; m_stall[g] = 0; m_flush[g] = 0; m_exrs[g] = 0; m_exrt[g] = 0;
    end
    // Reset values, including with hazard/branch inputs active during reset.
    idle_inputs();
    tick();
    set_lw_hazard(5'd2); m_branch = 1; m_zero = 1;
    tick();
    idle_inputs();
    reset = 1;
    tick();

    // lw $2 in EX, ID reads $2: 1/2/3 bubbles depending on instance.
    set_lw_hazard(5'd2);
    tick();
    idle_inputs();
    repeat (3) tick();

    // Async reset while the LU_STALL=2 instance is in STALL with cnt=1.
    set_lw_hazard(5'd3);
    tick();
    idle_inputs();
    reset = 0;
    tick();
    reset = 1;
    tick();

    // Taken branch during the stall sequence cancels it.
    set_lw_hazard(5'd4); id_rt = 5'd4; id_rs = 5'd1;
    tick();
    idle_inputs();
    m_branch = 1; m_zero = 1;
    tick();
    idle_inputs();
    m_branch = 1; m_zero = 0;   // untaken beq
    tick();
    idle_inputs();
    tick();

    // Forwarding: EX/MEM and MEM/WB both write $5, EX reads rs=5, rt=0.
    id_rs = 5'd5; id_rt = 5'd0;
    tick();
    m_regW = 1; m_dest = 5'd5; wb_regW = 1; wb_dest = 5'd5;
    tick();
    m_memR = 1;
    tick();
    m_memR = 0; m_regW = 0; id_rs = 5'd6; id_rt = 5'd5;
    tick();
    tick();
    idle_inputs();
    tick();

    // Hold together with a taken branch, then release.
    ext_hold = 1; m_branch = 1; m_zero = 1;
    repeat (2) tick();
    ext_hold = 0;
    tick();
    idle_inputs();
    tick();

    // Hold in the middle of a stall sequence.
    set_lw_hazard(5'd7);
    tick();
    idle_inputs();
    ext_hold = 1;
    tick();
    ext_hold = 0;
    repeat (3) tick();

    // Saturate both counters.
    set_lw_hazard(5'd9);
    repeat (CNT_MAX + 3) tick();
    idle_inputs();
    m_branch = 1; m_zero = 1;
    repeat (CNT_MAX + 3) tick();
    set_lw_hazard(5'd9);
    tick();
    idle_inputs();
    repeat (3) tick();

    // Randomised traffic over a small register window to provoke matches.
    reset = 0;
    tick();
    reset = 1;
    for (int i = 0; i < 400; i++) begin
      ext_hold = ($urandom_range(0, 7) == 0);
      id_rs    = 5'($urandom_range(0, 3));
      id_rt    = 5'($urandom_range(0, 3));
      ex_memR  = 1'($urandom_range(0, 1));
      ex_regW  = ($urandom_range(0, 3) != 0);
      ex_dest  = 5'($urandom_range(0, 3));
      m_regW   = 1'($urandom_range(0, 1));
      m_memR   = ($urandom_range(0, 3) == 0);
      m_dest   = 5'($urandom_range(0, 3));
      m_branch = ($urandom_range(0, 5) == 0);
      m_zero   = 1'($urandom_range(0, 1));
      wb_regW  = 1'($urandom_range(0, 1));
      wb_dest  = 5'($urandom_range(0, 3));
      reset    = ($urandom_range(0, 63) != 0);
      tick();
    end
    reset = 1;
    idle_inputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
